// File: rtl/shift_req_arbiter.sv
// Round-robin arbiter sharing one registered barrel shifter among NREQ requesters.
// One request in flight at a time: IDLE grants, SHIFT computes, RESP holds the result.
module shift_req_arbiter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned SHW   = 2,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_data,
   input  logic [NREQ*SHW-1:0]   req_shift,
   input  logic [NREQ-1:0]       req_dir,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WIDTH-1:0]      rsp_data,
   output logic [IDW-1:0]        rsp_id,
   output logic                  busy
);

   typedef enum logic [1:0] {StIdle, StShift, StResp} state_e;

   state_e             state_q, state_d;
   logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [WIDTH-1:0]   op_data_q, op_data_d;
   logic [SHW-1:0]     op_shift_q, op_shift_d;
   logic               op_dir_q, op_dir_d;
   logic [IDW-1:0]     op_id_q, op_id_d;
   logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic [IDW-1:0]     rsp_id_q, rsp_id_d;
   logic               rsp_valid_q, rsp_valid_d;

   logic [2*NREQ-1:0]  req_rot;
   logic               found;
   logic [IDW:0]       grant_sum;
   logic [IDW-1:0]     grant_id;
   logic [NREQ-1:0]    grant;
   logic [WIDTH-1:0]   shift_res;

   // Rotate the doubled valid vector so bit 0 is the requester at rr_ptr.
   always_comb begin
      req_rot   = {req_valid, req_valid} >> rr_ptr_q;
      found     = 1'b0;
      grant_sum = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (!found && req_rot[i]) begin
            found     = 1'b1;
            grant_sum = (IDW+1)'(rr_ptr_q) + (IDW+1)'(i);
         end
      end
      if (grant_sum >= (IDW+1)'(NREQ)) begin
         grant_sum = grant_sum - (IDW+1)'(NREQ);
      end
      grant_id = grant_sum[IDW-1:0];
      grant    = found ? (NREQ'(1) << grant_id) : '0;
   end

   assign shift_res = op_dir_q ? (op_data_q << op_shift_q) : (op_data_q >> op_shift_q);

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      op_data_d   = op_data_q;
      op_shift_d  = op_shift_q;
      op_dir_d    = op_dir_q;
      op_id_d     = op_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      rsp_valid_d = rsp_valid_q;
      req_ready   = '0;
      unique case (state_q)
         StIdle: begin
            req_ready = rst_n ? grant : '0;
            if (found) begin
               op_data_d  = req_data[grant_id*WIDTH +: WIDTH];
               op_shift_d = req_shift[grant_id*SHW +: SHW];
               op_dir_d   = req_dir[grant_id];
               op_id_d    = grant_id;
               rr_ptr_d   = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
               state_d    = StShift;
            end
         end
         StShift: begin
            rsp_data_d  = shift_res;
            rsp_id_d    = op_id_q;
            rsp_valid_d = 1'b1;
            state_d     = StResp;
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         op_data_q   <= '0;
         op_shift_q  <= '0;
         op_dir_q    <= 1'b0;
         op_id_q     <= '0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         op_data_q   <= op_data_d;
         op_shift_q  <= op_shift_d;
         op_dir_q    <= op_dir_d;
         op_id_q     <= op_id_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: doc/shift_req_arbiter.md
Name: shift_req_arbiter

Overview:
- Shares one logical barrel shifter datapath among NREQ requesters.
- Each requester offers an operand, shift amount and direction over a valid/ready handshake.
- The block grants one request at a time, round-robin, and computes the shift in a registered stage.
- It returns the result with the requester ID over a valid/ready response channel, and sits between the requesting units and the shared shifter resource.

Parameters:
WIDTH, 4, operand/result width in bits
SHW, 2, shift-amount width; legal shift 0..2^SHW-1
NREQ, 4, number of requesters (2..8)
IDW, 2, width of rsp_id; must satisfy 2^IDW >= NREQ

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_data  in  NREQ*WIDTH  operands; requester i at [i*WIDTH +: WIDTH]
req_shift  in  NREQ*SHW  shift amounts; requester i at [i*SHW +: SHW]
req_dir  in  NREQ  direction: 0 = logical right, 1 = logical left
rsp_valid  out  1  result valid
rsp_ready  in  1  downstream accepts result
rsp_data  out  WIDTH  shifted result
rsp_id  out  IDW  index of requester that owns rsp_data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, rr_ptr=0.
  - rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
  - Operand registers cleared.
  - req_ready=0 while rst_n=0.
- Reset mid-operation: any captured or pending result is discarded, rsp_valid drops at that edge, and there is no partial response.
- FSM has three states: IDLE, SHIFT, RESP.
- IDLE:
  - req_ready is combinational: a one-hot grant to the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - If no requester is valid, req_ready=0.
  - On an edge with a grant: capture data/shift/dir/id of the granted requester, set rr_ptr = granted+1 (mod NREQ), go to SHIFT.
- SHIFT:
  - req_ready=0.
  - Compute result = dir ? (data << shift) : (data >> shift). Both are logical, zero-fill, truncated to WIDTH; bits shifted out are lost.
  - Register result into rsp_data and id into rsp_id, set rsp_valid=1, go to RESP.
- RESP:
  - req_ready=0.
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_ready=1 at an edge.
  - On that edge: rsp_valid=0, go to IDLE.
  - There is no same-cycle re-grant in RESP; a new grant is possible in the following IDLE cycle.
- Latency: request accepted at edge N gives rsp_valid=1 after edge N+1. The minimum issue interval is 3 cycles with rsp_ready held high.
- shift=0 passes data unchanged in either direction.
- A requester holding req_valid while not granted must keep its operands stable. The block samples operands only on the grant edge.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0,... Any requester waits at most NREQ-1 other grants.
- A requester dropping req_valid before grant is legal; it is simply skipped.
- busy=1 in SHIFT and RESP, 0 in IDLE.
- rsp_ready is ignored outside RESP.

Test Plan:
1. Right shift and pass-through: req0 only, data=4'b1101, dir=0, shifts 0/1/2 issued sequentially -> rsp_data=1101, 0110, 0011; rsp_id=0; rsp_valid rises 2 cycles after each accept.
2. Left shift: req2 only, data=4'b1101, dir=1, shifts 1/2/3 -> rsp_data=1010, 0100, 1000; rsp_id=2.
3. Round-robin fairness: all four valid from reset with distinct data, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0; req_ready one-hot and asserted only in IDLE.
4. Backpressure: one request in flight, rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_id unchanged, req_ready=0, busy=1 throughout; a single handshake occurs when rsp_ready rises.
5. Reset mid-operation: rst_n=0 for 1 cycle while in SHIFT, then in RESP on a second run -> rsp_valid=0, busy=0, rr_ptr=0 next cycle; next grant goes to the lowest valid index.
6. Skip of dropped request: req1 valid then deasserted before grant while req3 valid, rr_ptr=1 -> grant goes to 3; rsp_id=3.
